burst_interrupter: RTL and testbench
====================================

Name: burst_interrupter

Overview:
- Downstream consumer of the UART config receiver's parameter bank.
- Takes the `inter_freq` and `inter_duty` bytes (config slots 3 and 4) and generates the DRSSTC burst gate `inter_en` that enables the drive/ref generator.
- Enforces a maximum on-time, at least one off tick per period, and fault lockout.
- Applies new parameters only at period boundaries, so UART updates never truncate or stretch a burst.

Parameters:
- PRESC_MAX, 499, tick prescaler terminal count; one tick every PRESC_MAX+1 clk cycles.
- MAX_ON, 40, maximum burst on-time in ticks (hardware duty ceiling).
- DATA_W, 8, width of inter_freq/inter_duty; matches the UART storage byte.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- arm  in  1  interrupter enable from the control logic; level-sensitive.
- fault  in  1  overcurrent trip (OCD) level; forces the burst off.
- inter_freq  in  DATA_W  period code; period = inter_freq+1 ticks; 0 disables output.
- inter_duty  in  DATA_W  requested on-time in ticks; 0 disables output.
- inter_en  out  1  registered burst gate.
- period_start  out  1  one-cycle strobe, registered, coincident with the inter_en rising edge.

Behaviour:
- Reset (synchronous, active-high, one clk with rst=1):
  - inter_en=0, period_start=0, state=IDLE, per_cnt=0, shadow regs=0.
  - Prescaler reloads to PRESC_MAX.
  - Reset has priority over every other event, including mid-burst.
- Prescaler:
  - Down-counts PRESC_MAX..0 and is free-running after reset.
  - tick=1 for the single cycle when the count is 0, then reloads.
- Shadow load: per_sh=inter_freq and on_sh=min(inter_duty, MAX_ON, inter_freq) are latched only at a period start. Input changes at any other time are ignored until the next period.
- start_ok = arm && !fault && inter_freq!=0 && inter_duty!=0.
- States: IDLE, ON, OFF.
- IDLE:
  - On tick && start_ok: load shadows, per_cnt<=0, inter_en<=1, period_start<=1, go to ON.
  - Otherwise stay.
  - inter_en rises exactly 1 clk after the tick cycle.
- ON, on each tick, per_cnt<=per_cnt+1:
  - If per_cnt+1==on_sh: inter_en<=0, go to OFF.
  - Result: high for exactly on_sh ticks.
- OFF, on each tick, per_cnt<=per_cnt+1:
  - If per_cnt+1==per_sh+1 (period end): when start_ok, do a period start as in IDLE (back-to-back, no gap cycle).
  - Otherwise go to IDLE.
  - Result: total period = per_sh+1 ticks.
- Guaranteed off time: on_sh<=inter_freq, so there is always at least 1 off tick per period.
- fault=1 in ON:
  - inter_en<=0 on the next clk (no wait for tick); go to OFF.
  - per_cnt keeps counting, so the period length is preserved.
  - Lockout: no restart while fault=1 at the period end; the block goes to IDLE instead.
- arm=0 in ON or OFF: go to IDLE on the next clk, inter_en<=0, per_cnt<=0.
- Simultaneous events, priority: rst > arm=0 > fault > tick-driven transitions.
- per_cnt width is DATA_W+1 bits. No wrap is possible because per_cnt never exceeds per_sh (max 255).
- period_start is high for exactly one clk and never while fault=1 or arm=0.

Decomposition:
- Shared package (alongside the existing uart typedefs):
  - Interrupter state enum {IR_IDLE, IR_ON, IR_OFF}.
  - Config-slot index constants (ref_gen=0, phase_shift=1, ocd_lvl=2, inter_freq=3, inter_duty=4), so the top level wires sh_reg slots by name.
- One sub-module: `tick_gen` (PRESC_MAX parameter, clk/rst in, tick out). It is reusable by the other timing blocks.

Test Plan (sim with PRESC_MAX=3, i.e. tick every 4 clk; MAX_ON=40):
- Basic: arm=1, freq=9, duty=3 -> period_start every 40 clk, inter_en high 12 clk and low 28 clk; the first rise is 1 clk after the first tick following arm.
- Clamp: freq=9, duty=50 -> on_sh=9, high 36 clk and low 4 clk. Then freq=200, duty=100 -> high 160 clk (MAX_ON=40 ticks).
- Mid-period update: freq=9, duty=3 running; set duty=6 at clk 5 of the burst -> current burst stays 12 clk, next burst 24 clk.
- Fault: pulse fault=1 for 2 clk at clk 6 of a burst -> inter_en low 1 clk later; the next period_start still occurs 40 clk after the previous one. Hold fault=1 across the period end -> no restart and state=IDLE.
- Disable paths:
  - freq=0 or duty=0 at a period end -> IDLE, inter_en stays 0.
  - arm=0 mid-burst -> inter_en=0 next clk; re-arm restarts on the next tick.
- Reset mid-burst: assert rst for 1 clk during ON -> all outputs 0, state IDLE next clk. Release with arm=1 -> the first burst starts on the first tick, after PRESC_MAX+1 clk.

Source files
------------

// File: rtl/burst_interrupter_pkg.sv
// Shared definitions for the config-bank consumers: slot map and interrupter state.
package burst_interrupter_pkg;

    localparam int unsigned CfgByteW = 8;
    typedef logic [CfgByteW-1:0] cfg_byte_t;

    // Parameter-bank slot indices written by the UART config receiver.
    localparam int unsigned NumCfgSlots    = 5;
    localparam int unsigned SlotRefGen     = 0;
    localparam int unsigned SlotPhaseShift = 1;
    localparam int unsigned SlotOcdLvl     = 2;
    localparam int unsigned SlotInterFreq  = 3;
    localparam int unsigned SlotInterDuty  = 4;

    typedef enum logic [1:0] {
        IR_IDLE = 2'd0,
        IR_ON   = 2'd1,
        IR_OFF  = 2'd2
    } ir_state_e;

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler: one-cycle tick every PRESC_MAX+1 clocks.
module tick_gen #(
    parameter int unsigned PRESC_MAX = 499
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int unsigned CntW = (PRESC_MAX > 0) ? $clog2(PRESC_MAX + 1) : 1;
    localparam logic [CntW-1:0] Reload = CntW'(PRESC_MAX);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = (cnt_q == '0) ? Reload : cnt_q - CntW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= Reload;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == '0);

endmodule

// File: rtl/burst_interrupter.sv
// DRSSTC burst gate: period/duty from the config bank, on-time ceiling, fault lockout,
// parameters applied only at period boundaries.
module burst_interrupter
    import burst_interrupter_pkg::*;
#(
    parameter int unsigned PRESC_MAX = 499,
    parameter int unsigned MAX_ON    = 40,
    parameter int unsigned DATA_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              arm,
    input  logic              fault,
    input  logic [DATA_W-1:0] inter_freq,
    input  logic [DATA_W-1:0] inter_duty,
    output logic              inter_en,
    output logic              period_start
);

    localparam int unsigned CntW     = DATA_W + 1;
    localparam int unsigned MaxOnSat = (MAX_ON < (1 << DATA_W)) ? MAX_ON : (1 << DATA_W) - 1;
    localparam logic [DATA_W-1:0] MaxOnC = DATA_W'(MaxOnSat);

    logic tick;

    tick_gen #(
        .PRESC_MAX(PRESC_MAX)
    ) u_tick_gen (
        .clk (clk),
        .rst (rst),
        .tick(tick)
    );

    ir_state_e         state_q, state_d;
    logic [CntW-1:0]   per_cnt_q, per_cnt_d;
    logic [DATA_W-1:0] per_sh_q, per_sh_d;
    logic [DATA_W-1:0] on_sh_q, on_sh_d;
    logic              inter_en_q, inter_en_d;
    logic              period_start_q, period_start_d;

    logic              start_ok;
    logic              start;
    logic [DATA_W-1:0] on_req;
    logic [CntW-1:0]   cnt_inc;
    logic              on_end;
    logic              per_end;

    assign start_ok = arm && !fault && (inter_freq != '0) && (inter_duty != '0);

    // Clamping to inter_freq guarantees at least one off tick per period.
    always_comb begin
        on_req = inter_duty;
        if (on_req > MaxOnC) begin
            on_req = MaxOnC;
        end
        if (on_req > inter_freq) begin
            on_req = inter_freq;
        end
    end

    assign cnt_inc = per_cnt_q + CntW'(1);
    assign on_end  = (cnt_inc == {1'b0, on_sh_q});
    assign per_end = (cnt_inc == ({1'b0, per_sh_q} + CntW'(1)));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IR_IDLE;
            per_cnt_q      <= '0;
            per_sh_q       <= '0;
            on_sh_q        <= '0;
            inter_en_q     <= 1'b0;
            period_start_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            per_cnt_q      <= per_cnt_d;
            per_sh_q       <= per_sh_d;
            on_sh_q        <= on_sh_d;
            inter_en_q     <= inter_en_d;
            period_start_q <= period_start_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        per_cnt_d = per_cnt_q;
        per_sh_d  = per_sh_q;
        on_sh_d   = on_sh_q;
        start     = 1'b0;

        case (state_q)
            IR_IDLE: begin
                start = tick && start_ok;
            end
            IR_ON: begin
                if (!arm) begin
                    state_d   = IR_IDLE;
                    per_cnt_d = '0;
                end else begin
                    // A fault cuts the burst at once but the period keeps its length.
                    if (tick) begin
                        per_cnt_d = cnt_inc;
                    end
                    if (fault || (tick && on_end)) begin
                        state_d = IR_OFF;
                    end
                end
            end
            IR_OFF: begin
                if (!arm) begin
                    state_d   = IR_IDLE;
                    per_cnt_d = '0;
                end else if (tick) begin
                    per_cnt_d = cnt_inc;
                    if (per_end) begin
                        if (start_ok) begin
                            start = 1'b1;
                        end else begin
                            state_d   = IR_IDLE;
                            per_cnt_d = '0;
                        end
                    end
                end
            end
            default: begin
                state_d   = IR_IDLE;
                per_cnt_d = '0;
            end
        endcase

        if (start) begin
            state_d   = IR_ON;
            per_cnt_d = '0;
            per_sh_d  = inter_freq;
            on_sh_d   = on_req;
        end
    end

    always_comb begin
        inter_en_d     = (state_d == IR_ON);
        period_start_d = start;
    end

    assign inter_en     = inter_en_q;
    assign period_start = period_start_q;

endmodule

// File: tb/tb_burst_interrupter.sv
// Randomized and directed bench for burst_interrupter against a period-level reference model.
module tb_burst_interrupter;
    import burst_interrupter_pkg::*;

    localparam int unsigned PRESC = 3;
    localparam int unsigned TPER  = PRESC + 1;
    localparam int unsigned MAXON = 40;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       arm = 1'b0;
    logic       fault = 1'b0;
    logic [7:0] freq = 8'd0;
    logic [7:0] duty = 8'd0;
    logic       inter_en;
    logic       period_start;

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;

    burst_interrupter #(
        .PRESC_MAX(PRESC),
        .MAX_ON   (MAXON),
        .DATA_W   (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .arm         (arm),
        .fault       (fault),
        .inter_freq  (freq),
        .inter_duty  (duty),
        .inter_en    (inter_en),
        .period_start(period_start)
    );

    always #5 clk = ~clk;

    // Reference model: a period is "active" for per+1 ticks; the gate is high for the
    // first `on` ticks unless a fault has cut it.
    int m_pre = 0;
    int m_t = 0;
    int m_per = 0;
    int m_on = 0;
    bit m_active = 1'b0;
    bit m_cut = 1'b0;
    bit exp_en = 1'b0;
    bit exp_ps = 1'b0;

    always @(posedge clk) begin
        bit tk;
        bit ok;
        bit st;
        if (rst) begin
            m_pre    = 0;
            m_active = 1'b0;
            m_cut    = 1'b0;
            m_t      = 0;
            exp_en   = 1'b0;
            exp_ps   = 1'b0;
        end else begin
            tk = ((m_pre % TPER) == PRESC);
            m_pre++;
            ok = arm && !fault && (freq != 0) && (duty != 0);
            st = 1'b0;
            exp_ps = 1'b0;
            if (m_active && !arm) begin
                m_active = 1'b0;
            end else if (m_active) begin
                if (fault) m_cut = 1'b1;
                if (tk) begin
                    m_t++;
                    if (m_t == m_per + 1) begin
                        m_active = 1'b0;
                        st = ok;
                    end
                end
            end else begin
                st = tk && ok;
            end
            if (st) begin
                m_active = 1'b1;
                m_cut    = 1'b0;
                m_t      = 0;
                m_per    = int'(freq);
                m_on     = int'(duty);
                if (m_on > MAXON) m_on = MAXON;
                if (m_on > m_per) m_on = m_per;
                exp_ps = 1'b1;
            end
            exp_en = m_active && !m_cut && (m_t < m_on);
        end
    end

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("inter_en", int'(inter_en), int'(exp_en));
            check("period_start", int'(period_start), int'(exp_ps));
        end
    end

    task automatic wait_ps();
        int n;
        n = 0;
        @(negedge clk);
        while (!period_start && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!period_start) timeout("wait_period_start");
    endtask

    // Called on the negedge where period_start is seen; returns on the next one.
    task automatic burst_len(output int h, output int p);
        h = 0;
        while (inter_en && h < 2000) begin
            h++;
            @(negedge clk);
        end
        p = h;
        while (!period_start && p < 4000) begin
            @(negedge clk);
            p++;
        end
        if (!period_start) timeout("burst_len");
    endtask

    task automatic count_rise(output int n);
        n = 0;
        while (!inter_en && n < 100) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        int h;
        int p;
        int n;
        int seen;

        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        check("reset_en", int'(inter_en), 0);
        check("reset_ps", int'(period_start), 0);
        check("reset_state", int'(dut.state_q), int'(IR_IDLE));

        // Basic: first rise one clk after the first tick.
        arm = 1'b1; freq = 8'd9; duty = 8'd3; rst = 1'b0;
        count_rise(n);
        check("first_rise", n, TPER);
        burst_len(h, p);
        check("basic_high", h, 12);
        check("basic_period", p, 40);

        // Clamp; the period already started keeps its old shadows.
        duty = 8'd50;
        burst_len(h, p);
        check("shadow_old_high", h, 12);
        burst_len(h, p);
        check("clamp_freq_high", h, 36);
        check("clamp_freq_period", p, 40);
        freq = 8'd200; duty = 8'd100;
        burst_len(h, p);
        burst_len(h, p);
        check("clamp_maxon_high", h, 160);
        check("clamp_maxon_period", p, 804);

        // Mid-period duty update.
        freq = 8'd9; duty = 8'd3;
        burst_len(h, p);
        h = 0;
        while (inter_en && h < 100) begin
            h++;
            if (h == 5) duty = 8'd6;
            @(negedge clk);
        end
        check("mid_cur_high", h, 12);
        wait_ps();
        burst_len(h, p);
        check("mid_next_high", h, 24);
        check("mid_next_period", p, 40);

        // Fault pulse: cut next clk, period length preserved.
        repeat (6) @(negedge clk);
        fault = 1'b1;
        @(negedge clk);
        check("fault_cut", int'(inter_en), 0);
        @(negedge clk);
        fault = 1'b0;
        p = 8;
        while (!period_start && p < 200) begin
            @(negedge clk);
            p++;
        end
        check("fault_period", p, 40);

        // Fault held across the period end: lockout.
        repeat (30) @(negedge clk);
        fault = 1'b1;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (period_start) seen++;
        end
        check("lockout_no_restart", seen, 0);
        check("lockout_state", int'(dut.state_q), int'(IR_IDLE));
        fault = 1'b0;
        wait_ps();

        // freq=0 at period end.
        freq = 8'd0;
        seen = 0;
        repeat (60) begin
            @(negedge clk);
            if (period_start) seen++;
        end
        check("freq0_no_restart", seen, 0);
        check("freq0_en", int'(inter_en), 0);
        freq = 8'd9;
        wait_ps();

        // arm=0 mid-burst.
        repeat (3) @(negedge clk);
        arm = 1'b0;
        @(negedge clk);
        check("disarm_en", int'(inter_en), 0);
        check("disarm_state", int'(dut.state_q), int'(IR_IDLE));
        arm = 1'b1;
        wait_ps();

        // Reset mid-burst.
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_en", int'(inter_en), 0);
        check("rst_mid_ps", int'(period_start), 0);
        check("rst_mid_state", int'(dut.state_q), int'(IR_IDLE));
        rst = 1'b0;
        count_rise(n);
        check("rst_restart", n, TPER);

        // Randomized traffic, checked every cycle by the model.
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 999) < 3);
            if ($urandom_range(0, 99) == 0) arm = ~arm;
            fault = ($urandom_range(0, 99) < 3);
            if ($urandom_range(0, 99) < 3)
                freq = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 60));
            if ($urandom_range(0, 99) < 3)
                duty = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 50));
        end
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
